// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t  : converter FSM state encoding
//   BCD_W    : bits per BCD digit
//   NUM_DIG  : number of BCD digits produced
//   DIG_NINE : digit value shown on every position when the input overflows
package bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int NUM_DIG = 4;
  localparam logic [BCD_W-1:0] DIG_NINE = 4'h9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit field that is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit.
//   i_dig : digit field before correction
//   o_dig : corrected digit field
module dd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_dig,
  output logic [BCD_W-1:0] o_dig
);

  // Inputs are 0..9 during a legal conversion, so 5..9 + 3 = 8..12 fits in 4 bits.
  always_comb begin
    o_dig = i_dig;
    if (i_dig >= 4'd5) begin
      o_dig = i_dig + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one add-3/shift per clock)
// feeding the four-digit seven-segment display stage.
//   CLK       : system clock, rising edge
//   RSTN      : synchronous active-low reset
//   START     : conversion request, sampled only while idle
//   BIN       : unsigned binary input, captured on the accepting edge
//   BUSY      : high whenever the converter is not idle
//   DONE      : one-cycle pulse when new digits are valid
//   OVF       : last accepted BIN exceeded MAX_VAL (digits then read 9999)
//   BCD0..3   : ones, tens, hundreds, thousands digits; held between conversions
//
// state   | meaning
// S_IDLE  | waiting for START; BUSY low
// S_SHIFT | W_BIN add-3/shift iterations on the scratch register
// S_DONE  | single cycle with DONE high, then back to idle
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W_BIN   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [W_BIN-1:0] BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [3:0]       BCD0,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD2,
  output logic [3:0]       BCD3
);

  localparam int SCR_W = BCD_W * NUM_DIG + W_BIN;
  localparam int CNT_W = $clog2(W_BIN + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_load;
  logic               w_last;
  logic               w_bin_ovf;

  logic [SCR_W-1:0]   r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_bcd [NUM_DIG];

  logic [BCD_W-1:0]   w_adj_dig [NUM_DIG];
  logic [SCR_W-1:0]   w_adj_scr;
  logic [SCR_W-1:0]   w_shift;

  assign w_bin_ovf = (32'(BIN) > 32'(MAX_VAL));

  // Digit fields sit above the binary part of the scratch register.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
    dd_digit_adj u_adj (
      .i_dig (r_scr[W_BIN + BCD_W*g +: BCD_W]),
      .o_dig (w_adj_dig[g])
    );
  end

  always_comb begin
    w_adj_scr = r_scr;
    for (int k = 0; k < NUM_DIG; k++) begin
      w_adj_scr[W_BIN + BCD_W*k +: BCD_W] = w_adj_dig[k];
    end
    w_shift = w_adj_scr << 1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next_state = S_SHIFT;
          w_load       = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(W_BIN - 1)) begin
          w_next_state = S_DONE;
          w_last       = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      for (int k = 0; k < NUM_DIG; k++) begin
        r_bcd[k] <= '0;
      end
    end else begin
      // BUSY/DONE are registered copies of where the FSM is heading.
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);

      if (w_load) begin
        r_scr      <= {{(BCD_W*NUM_DIG){1'b0}}, BIN};
        r_cnt      <= '0;
        r_ovf_pend <= w_bin_ovf;
      end else if (r_state == S_SHIFT) begin
        r_scr <= w_shift;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_last) begin
        r_ovf <= r_ovf_pend;
        for (int k = 0; k < NUM_DIG; k++) begin
          r_bcd[k] <= r_ovf_pend ? DIG_NINE : w_shift[W_BIN + BCD_W*k +: BCD_W];
        end
      end
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign OVF  = r_ovf;
  assign BCD0 = r_bcd[0];
  assign BCD1 = r_bcd[1];
  assign BCD2 = r_bcd[2];
  assign BCD3 = r_bcd[3];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START;
  logic [13:0] BIN;
  logic        BUSY, DONE, OVF;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3;
  logic [15:0] w_dig;

  int nvec = 0;
  int nerr = 0;

  bin_to_bcd_seq #(.W_BIN(14), .MAX_VAL(9999)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OVF   (OVF),
    .BCD0  (BCD0),
    .BCD1  (BCD1),
    .BCD2  (BCD2),
    .BCD3  (BCD3)
  );

  assign w_dig = {BCD3, BCD2, BCD1, BCD0};

  always #5 CLK = ~CLK;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] dig;
    logic        ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Issues START for one cycle, then waits (bounded) for DONE and checks
  // latency, result, hold of outputs while busy, and the single-cycle pulse.
  task automatic convert(input logic [13:0] b, input logic [15:0] exp_dig,
                         input logic exp_ovf, input string nm);
    logic [15:0] prev_dig;
    logic        prev_ovf;
    int          lat;
    bit          hold;
    BIN   = b;
    START = 1'b1;
    step();
    START = 1'b0;
    chk({nm, " busy_accept"}, BUSY, 1);
    prev_dig = w_dig;
    prev_ovf = OVF;
    hold     = 1'b1;
    lat      = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (DONE) begin
        lat = i;
        break;
      end
      if (w_dig !== prev_dig || OVF !== prev_ovf || BUSY !== 1'b1) hold = 1'b0;
    end
    chk({nm, " latency"}, lat, 14);
    chk({nm, " hold"}, hold, 1);
    chk({nm, " digits"}, w_dig, exp_dig);
    chk({nm, " ovf"}, OVF, exp_ovf);
    chk({nm, " busy_done"}, BUSY, 1);
    step();
    chk({nm, " done_1cyc"}, {BUSY, DONE}, 0);
  endtask

  initial begin
    int d1, d2, v;
    bit saw_done;

    tbl[0]  = '{14'd1234,  16'h1234, 1'b0};
    tbl[1]  = '{14'd0,     16'h0000, 1'b0};
    tbl[2]  = '{14'd9999,  16'h9999, 1'b0};
    tbl[3]  = '{14'd5,     16'h0005, 1'b0};
    tbl[4]  = '{14'd12000, 16'h9999, 1'b1};
    tbl[5]  = '{14'd42,    16'h0042, 1'b0};
    tbl[6]  = '{14'd10000, 16'h9999, 1'b1};
    tbl[7]  = '{14'd16383, 16'h9999, 1'b1};
    tbl[8]  = '{14'd1000,  16'h1000, 1'b0};
    tbl[9]  = '{14'd8080,  16'h8080, 1'b0};
    tbl[10] = '{14'd987,   16'h0987, 1'b0};

    RSTN  = 1'b0;
    START = 1'b0;
    BIN   = '0;
    step();
    step();
    chk("reset flags", {BUSY, DONE, OVF}, 0);
    chk("reset digits", w_dig, 0);
    RSTN = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      convert(tbl[i].bin, tbl[i].dig, tbl[i].ovf, $sformatf("tbl%0d", i));
    end

    // Leave nonzero digits and OVF set, then reset mid-conversion.
    convert(14'd12000, 16'h9999, 1'b1, "pre_rst");
    BIN   = 14'd1234;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (4) step();
    RSTN = 1'b0;
    step();
    chk("midrst flags", {BUSY, DONE, OVF}, 0);
    chk("midrst digits", w_dig, 0);
    RSTN = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (DONE || BUSY) saw_done = 1'b1;
    end
    chk("midrst no_done", saw_done, 0);

    // Reset and START together: reset wins.
    RSTN  = 1'b0;
    START = 1'b1;
    BIN   = 14'd77;
    step();
    chk("rst_vs_start busy", BUSY, 0);
    RSTN  = 1'b1;
    START = 1'b0;
    step();
    chk("rst_vs_start idle", BUSY, 0);

    // START held high: one conversion every 16 cycles; BIN wiggle ignored.
    BIN   = 14'd8080;
    START = 1'b1;
    step();
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 31; i++) begin
      if (i == 3) BIN = 14'd1;
      if (i == 8) BIN = 14'd8080;
      step();
      if (DONE) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
        chk($sformatf("cont digits@%0d", i), w_dig, 16'h8080);
      end
      if (i == 15) chk("cont idle_gap", BUSY, 0);
      if (i == 16) chk("cont reaccept", BUSY, 1);
    end
    START = 1'b0;
    chk("cont first_done", d1, 14);
    chk("cont second_done", d2, 30);
    step();

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 16383));
      convert(14'(v), ref_bcd(v), (v > 9999), $sformatf("rand%0d_v%0d", i, v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
